// File: rtl/ula_arbiter.sv
// ula_arbiter: two-requester round-robin sequencer for one shared ula; grant counters with ULA_ARB_STATS_EN
module ula (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [3:0]  sel,
  output logic [15:0] result,
  output logic        zero_flag,
  output logic        sign_flag
);
  always_comb begin
    case (sel)
      4'd0:    result = {8'h00, a} + {8'h00, b};
      4'd1:    result = {8'h00, a} - {8'h00, b};
      4'd2:    result = {8'h00, a} * {8'h00, b};
      4'd3:    result = {8'h00, a & b};
      4'd4:    result = {8'h00, a | b};
      4'd5:    result = {8'h00, ~(a & b)};
      4'd6:    result = {8'h00, a ^ b};
      4'd7:    result = {8'h00, ~(a | b)};
      4'd8:    result = {15'h0000, a == b};
      4'd9:    result = {15'h0000, a >= b};
      4'd10:   result = {15'h0000, a <= b};
      default: result = 16'h0000;
    endcase
  end
  assign zero_flag = result == 16'h0000;
  assign sign_flag = result[15];
endmodule

module ula_arbiter #(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [7:0]        req_a0,
  input  logic [7:0]        req_b0,
  input  logic [7:0]        req_a1,
  input  logic [7:0]        req_b1,
  input  logic [3:0]        req_op0,
  input  logic [3:0]        req_op1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [15:0]       rsp_result,
  output logic              rsp_zero,
  output logic              rsp_sign,
  output logic              busy
`ifdef ULA_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1
`endif
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic prio, gnt, win, accept, hs, illegal;
  logic [7:0] a_r, b_r;
  logic [3:0] op_r;
  logic [15:0] ula_res;
  logic ula_zero, ula_sign;
  assign win = &req_valid ? prio : req_valid[1];
  // outputs are held quiet while rst is asserted so a mid-operation reset emits nothing
  assign accept = !rst && state == IDLE && |req_valid;
  assign req_ready = accept ? {win, ~win} : 2'b00;
  assign rsp_valid = (!rst && state == RESP) ? {gnt, ~gnt} : 2'b00;
  assign busy = !rst && state != IDLE;
  assign hs = state == RESP && rsp_ready[gnt];
  assign illegal = op_r > 4'd10;
  ula u_ula (
    .a(a_r),
    .b(b_r),
    .sel(op_r),
    .result(ula_res),
    .zero_flag(ula_zero),
    .sign_flag(ula_sign)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio <= 1'b0;
      gnt <= 1'b0;
      a_r <= 8'h00;
      b_r <= 8'h00;
      op_r <= 4'h0;
      rsp_result <= 16'h0000;
      rsp_zero <= 1'b0;
      rsp_sign <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          gnt <= win;
          a_r <= win ? req_a1 : req_a0;
          b_r <= win ? req_b1 : req_b0;
          op_r <= win ? req_op1 : req_op0;
          state <= EXEC;
        end
        EXEC: begin
          rsp_result <= illegal ? 16'h0000 : ula_res;
          rsp_zero <= illegal ? 1'b1 : ula_zero;
          rsp_sign <= illegal ? 1'b0 : ula_sign;
          state <= RESP;
        end
        RESP: if (hs) begin
          prio <= ~gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ULA_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req_ready[0] && !(&grant_cnt0)) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req_ready[1] && !(&grant_cnt1)) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`else
  localparam int STAT_W_UNUSED = STAT_W;
`endif
endmodule
